caf_slice_driver: RTL and testbench
===================================

CAF_SLICE_DRIVER -- requirements
Module: caf_slice_driver

Interface
REQ-001 SHALL have parameter phase_bits, default 10, width of freq_step and num_steps.
REQ-002 SHALL have parameters xi_bits, xq_bits, yi_bits, yq_bits, default 12 each, sample component widths.
REQ-003 SHALL have parameter length, default 5, samples streamed per frequency step.
REQ-004 SHALL have parameter length_counter_bits, default 3, width of sample address and index.
REQ-005 SHALL have parameter out_max_bits, default 5, width of correlation magnitude.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 wr_en, wr_addr, wr_xi, wr_xq, wr_yi, wr_yq  in  1/length_counter_bits/xi/xq/yi/yq_bits  buffer load port.
REQ-009 start, num_steps  in  1/phase_bits  sweep request and number of step magnitudes.
REQ-010 freq_step, freq_step_valid, neg_shift  out  phase_bits/1/1  frequency programming to the slice.
REQ-011 xi, xq, yi, yq, s_axis_tvalid  out  sample widths/1  sample stream to the slice.
REQ-012 m_axis_tready  in  1  slice ready to accept a sample.
REQ-013 res_tvalid, res_max, res_index  in  1/out_max_bits/length_counter_bits  slice result.
REQ-014 res_tready  out  1  driver ready to accept a result.
REQ-015 best_max, best_index, best_step, best_neg, busy, done  out  out_max_bits/length_counter_bits/phase_bits/1/1/1  sweep result and status.

Function
REQ-016 SHALL hold x and y buffers of length entries; wr_en writes all four components at wr_addr when FSM is IDLE or DONE; writes at other times and wr_addr >= length SHALL be ignored.
REQ-017 FSM states: IDLE, PROG, STREAM, WAIT_RES, NEXT, DONE.
REQ-018 IDLE/DONE + start with num_steps != 0 -> PROG, step k=0, neg=0, best_max cleared to 0, done=0; start with num_steps == 0 -> DONE with best_* = 0.
REQ-019 start SHALL be ignored in PROG, STREAM, WAIT_RES, NEXT.
REQ-020 PROG lasts exactly one cycle: freq_step_valid=1, freq_step=k, neg_shift=neg; then STREAM with address 0.
REQ-021 freq_step and neg_shift SHALL remain stable from PROG through NEXT.
REQ-022 STREAM: s_axis_tvalid=1, xi/xq/yi/yq = buffer[address]; address advances only on s_axis_tvalid & m_axis_tready; data SHALL stay stable while stalled.
REQ-023 Transfer at address length-1 -> WAIT_RES; s_axis_tvalid=0 next cycle; exactly length transfers per step.
REQ-024 WAIT_RES: res_tready=1; on res_tvalid capture result and go NEXT; res_tready=0 in all other states.
REQ-025 Compare in NEXT: res_max strictly greater than best_max replaces best_max, best_index, best_step=k, best_neg=neg; ties keep earlier entry; first step always replaces when res_max > 0.
REQ-026 Step order: k=0 positive only; each k>=1 positive then negative; NEXT advances neg 0->1 for k>=1, else k+1, neg=0.
REQ-027 NEXT after last entry (k=num_steps-1, neg=1, or num_steps=1) -> DONE; otherwise -> PROG.
REQ-028 busy=1 in PROG, STREAM, WAIT_RES, NEXT; done=1 only in DONE and held until next accepted start.
REQ-029 num_steps SHALL be latched on accepted start; later changes ignored mid-sweep.
REQ-030 Total steps per sweep SHALL equal 2*num_steps-1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and all outputs to 0, including mid-sweep; buffer contents need not be cleared.
REQ-032 After rst_n rises, no transfer or freq_step_valid SHALL occur until a new start.

Verification
REQ-033 length=5, num_steps=1, m_axis_tready=1, result res_max=7 idx=2 -> one freq_step_valid pulse (step 0, neg 0), 5 transfers, done=1, best_max=7, best_index=2, best_step=0.
REQ-034 num_steps=3 -> sequence (0,+),(1,+),(1,-),(2,+),(2,-); 5 freq_step_valid pulses, 25 transfers.
REQ-035 m_axis_tready toggled 0/1 every cycle -> samples delivered in order 0..4, each held stable while stalled, no duplicates.
REQ-036 results 4,9,9,3,9 over num_steps=3 -> best_max=9, best_step=1, best_neg=0 (tie keeps first).
REQ-037 rst_n pulsed low during STREAM -> s_axis_tvalid, busy, done drop to 0 asynchronously; restart sweep completes correctly.
REQ-038 wr_en during busy and start during busy -> buffer unchanged, sweep unaffected.

Source files
------------

// File: rtl/caf_slice_driver.sv
// Sweep driver for a cross-ambiguity-function slice: programs each frequency step, streams the
// buffered x/y samples, collects the slice result and keeps the strongest peak over the sweep.
module caf_slice_driver #(
  parameter int unsigned phase_bits          = 10,
  parameter int unsigned xi_bits             = 12,
  parameter int unsigned xq_bits             = 12,
  parameter int unsigned yi_bits             = 12,
  parameter int unsigned yq_bits             = 12,
  parameter int unsigned length              = 5,
  parameter int unsigned length_counter_bits = 3,
  parameter int unsigned out_max_bits        = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // buffer load port
  input  logic                           wr_en,
  input  logic [length_counter_bits-1:0] wr_addr,
  input  logic [xi_bits-1:0]             wr_xi,
  input  logic [xq_bits-1:0]             wr_xq,
  input  logic [yi_bits-1:0]             wr_yi,
  input  logic [yq_bits-1:0]             wr_yq,
  // sweep request
  input  logic                           start,
  input  logic [phase_bits-1:0]          num_steps,
  // frequency programming
  output logic [phase_bits-1:0]          freq_step,
  output logic                           freq_step_valid,
  output logic                           neg_shift,
  // sample stream
  output logic [xi_bits-1:0]             xi,
  output logic [xq_bits-1:0]             xq,
  output logic [yi_bits-1:0]             yi,
  output logic [yq_bits-1:0]             yq,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready,
  // slice result
  input  logic                           res_tvalid,
  input  logic [out_max_bits-1:0]        res_max,
  input  logic [length_counter_bits-1:0] res_index,
  output logic                           res_tready,
  // sweep result and status
  output logic [out_max_bits-1:0]        best_max,
  output logic [length_counter_bits-1:0] best_index,
  output logic [phase_bits-1:0]          best_step,
  output logic                           best_neg,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [2:0] {
    StIdle, StProg, StStream, StWaitRes, StNext, StDone
  } state_e;

  localparam logic [length_counter_bits-1:0] LastAddr = length_counter_bits'(length - 1);

  state_e                         state_q, state_d;
  logic [phase_bits-1:0]          k_q, k_d;
  logic                           neg_q, neg_d;
  logic [phase_bits-1:0]          nsteps_q, nsteps_d;
  logic [length_counter_bits-1:0] addr_q, addr_d;
  logic [out_max_bits-1:0]        res_max_q, res_max_d;
  logic [length_counter_bits-1:0] res_idx_q, res_idx_d;
  logic [out_max_bits-1:0]        best_max_q, best_max_d;
  logic [length_counter_bits-1:0] best_index_q, best_index_d;
  logic [phase_bits-1:0]          best_step_q, best_step_d;
  logic                           best_neg_q, best_neg_d;

  logic [xi_bits-1:0] buf_xi_q [length];
  logic [xq_bits-1:0] buf_xq_q [length];
  logic [yi_bits-1:0] buf_yi_q [length];
  logic [yq_bits-1:0] buf_yq_q [length];

  logic idle_or_done;
  logic wr_ok;
  logic last_entry;

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign wr_ok        = wr_en && idle_or_done && (32'(wr_addr) < length);
  // Step 0 has only a positive entry; every later step ends on its negative entry.
  assign last_entry   = (k_q == nsteps_q - phase_bits'(1)) && (neg_q || (k_q == '0));

  // Sample buffers carry no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      buf_xi_q[wr_addr] <= wr_xi;
      buf_xq_q[wr_addr] <= wr_xq;
      buf_yi_q[wr_addr] <= wr_yi;
      buf_yq_q[wr_addr] <= wr_yq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      neg_q        <= 1'b0;
      nsteps_q     <= '0;
      addr_q       <= '0;
      res_max_q    <= '0;
      res_idx_q    <= '0;
      best_max_q   <= '0;
      best_index_q <= '0;
      best_step_q  <= '0;
      best_neg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      neg_q        <= neg_d;
      nsteps_q     <= nsteps_d;
      addr_q       <= addr_d;
      res_max_q    <= res_max_d;
      res_idx_q    <= res_idx_d;
      best_max_q   <= best_max_d;
      best_index_q <= best_index_d;
      best_step_q  <= best_step_d;
      best_neg_q   <= best_neg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    neg_d        = neg_q;
    nsteps_d     = nsteps_q;
    addr_d       = addr_q;
    res_max_d    = res_max_q;
    res_idx_d    = res_idx_q;
    best_max_d   = best_max_q;
    best_index_d = best_index_q;
    best_step_d  = best_step_q;
    best_neg_d   = best_neg_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          nsteps_d     = num_steps;
          k_d          = '0;
          neg_d        = 1'b0;
          best_max_d   = '0;
          best_index_d = '0;
          best_step_d  = '0;
          best_neg_d   = 1'b0;
          state_d      = (num_steps != '0) ? StProg : StDone;
        end
      end
      StProg: begin
        addr_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        if (m_axis_tready) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StWaitRes;
          end else begin
            addr_d = addr_q + length_counter_bits'(1);
          end
        end
      end
      StWaitRes: begin
        if (res_tvalid) begin
          res_max_d = res_max;
          res_idx_d = res_index;
          state_d   = StNext;
        end
      end
      StNext: begin
        // Strictly greater: ties keep the earlier entry.
        if (res_max_q > best_max_q) begin
          best_max_d   = res_max_q;
          best_index_d = res_idx_q;
          best_step_d  = k_q;
          best_neg_d   = neg_q;
        end
        if (last_entry) begin
          state_d = StDone;
        end else begin
          if (neg_q || (k_q == '0)) begin
            k_d   = k_q + phase_bits'(1);
            neg_d = 1'b0;
          end else begin
            neg_d = 1'b1;
          end
          state_d = StProg;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    freq_step_valid = 1'b0;
    s_axis_tvalid   = 1'b0;
    res_tready      = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    xi              = '0;
    xq              = '0;
    yi              = '0;
    yq              = '0;

    unique case (state_q)
      StProg: begin
        freq_step_valid = 1'b1;
        busy            = 1'b1;
      end
      StStream: begin
        s_axis_tvalid = 1'b1;
        busy          = 1'b1;
        xi            = buf_xi_q[addr_q];
        xq            = buf_xq_q[addr_q];
        yi            = buf_yi_q[addr_q];
        yq            = buf_yq_q[addr_q];
      end
      StWaitRes: begin
        res_tready = 1'b1;
        busy       = 1'b1;
      end
      StNext:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign freq_step  = k_q;
  assign neg_shift  = neg_q;
  assign best_max   = best_max_q;
  assign best_index = best_index_q;
  assign best_step  = best_step_q;
  assign best_neg   = best_neg_q;

endmodule

// File: tb/tb_caf_slice_driver.sv
// Directed bench for caf_slice_driver: plays the slice side of the handshakes and checks step
// order, streamed samples, best-peak selection, reset behaviour and busy-time input immunity.
module tb_caf_slice_driver;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_xi = '0, wr_xq = '0, wr_yi = '0, wr_yq = '0;
  logic        start = 1'b0;
  logic [9:0]  num_steps = '0;
  logic [9:0]  freq_step;
  logic        freq_step_valid, neg_shift;
  logic [11:0] xi, xq, yi, yq;
  logic        s_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        res_tvalid = 1'b0;
  logic [4:0]  res_max = '0;
  logic [2:0]  res_index = '0;
  logic        res_tready;
  logic [4:0]  best_max;
  logic [2:0]  best_index;
  logic [9:0]  best_step;
  logic        best_neg, busy, done;

  int n_checks = 0;
  int n_fails = 0;

  logic [11:0] bx_i [L];
  logic [11:0] bx_q [L];
  logic [11:0] by_i [L];
  logic [11:0] by_q [L];
  int tab_max [8];
  int tab_idx [8];
  int pcode [16];
  int pcnt, xfers, data_err, nres;

  caf_slice_driver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_xi          (wr_xi),
    .wr_xq          (wr_xq),
    .wr_yi          (wr_yi),
    .wr_yq          (wr_yq),
    .start          (start),
    .num_steps      (num_steps),
    .freq_step      (freq_step),
    .freq_step_valid(freq_step_valid),
    .neg_shift      (neg_shift),
    .xi             (xi),
    .xq             (xq),
    .yi             (yi),
    .yq             (yq),
    .s_axis_tvalid  (s_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .res_tvalid     (res_tvalid),
    .res_max        (res_max),
    .res_index      (res_index),
    .res_tready     (res_tready),
    .best_max       (best_max),
    .best_index     (best_index),
    .best_step      (best_step),
    .best_neg       (best_neg),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a sweep and act as the slice until done (bounded). Inputs change on negedges.
  task automatic run_sweep(input int n, input bit tog, input bit disturb);
    int e;
    pcnt = 0; xfers = 0; data_err = 0; nres = 0;
    @(negedge clk);
    start = 1'b1;
    num_steps = 10'(n);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0; wr_en = 1'b0; res_tvalid = 1'b0;
        break;
      end
      start = disturb;
      if (disturb) num_steps = 10'd7;
      wr_en = disturb; wr_addr = 3'(cyc % L);
      wr_xi = 12'hfff; wr_xq = 12'hfff; wr_yi = 12'hfff; wr_yq = 12'hfff;
      if (freq_step_valid) begin
        if (pcnt < 16) pcode[pcnt] = int'(freq_step) * 2 + int'(neg_shift);
        pcnt++;
      end
      m_axis_tready = tog ? cyc[0] : 1'b1;
      if (s_axis_tvalid) begin
        e = xfers % L;
        if (xi !== bx_i[e] || xq !== bx_q[e] || yi !== by_i[e] || yq !== by_q[e]) data_err++;
        if (m_axis_tready) xfers++;
      end
      if (res_tready && nres < 8) begin
        res_tvalid = 1'b1;
        res_max    = 5'(tab_max[nres]);
        res_index  = 3'(tab_idx[nres]);
        nres++;
      end else begin
        res_tvalid = 1'b0;
      end
    end
    start = 1'b0; wr_en = 1'b0; num_steps = '0;
    check("sweep_done", done, 1);
  endtask

  initial begin
    int exp_code [5];
    int err;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tvalid", s_axis_tvalid, 0);
    check("rst_fsv", freq_step_valid, 0);
    check("rst_res_tready", res_tready, 0);
    check("rst_best_max", best_max, 0);
    rst_n = 1'b1;

    // Load buffers
    for (int a = 0; a < L; a++) begin
      bx_i[a] = 12'(100 + a); bx_q[a] = 12'(200 + a);
      by_i[a] = 12'(300 + a); by_q[a] = 12'(400 + a);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(a);
      wr_xi = bx_i[a]; wr_xq = bx_q[a]; wr_yi = by_i[a]; wr_yq = by_q[a];
    end
    @(negedge clk);
    wr_en = 1'b0;

    // Single step, result 7 at index 2
    tab_max[0] = 7; tab_idx[0] = 2;
    run_sweep(1, 1'b0, 1'b0);
    check("s1_pulses", pcnt, 1);
    check("s1_code", pcode[0], 0);
    check("s1_xfers", xfers, 5);
    check("s1_data", data_err, 0);
    check("s1_best_max", best_max, 7);
    check("s1_best_index", best_index, 2);
    check("s1_best_step", best_step, 0);
    check("s1_busy", busy, 0);

    // Three steps, results 4,9,9,3,9: first 9 wins
    tab_max[0] = 4; tab_idx[0] = 1;
    tab_max[1] = 9; tab_idx[1] = 3;
    tab_max[2] = 9; tab_idx[2] = 4;
    tab_max[3] = 3; tab_idx[3] = 0;
    tab_max[4] = 9; tab_idx[4] = 2;
    run_sweep(3, 1'b0, 1'b0);
    exp_code = '{0, 2, 3, 4, 5};
    check("s3_pulses", pcnt, 5);
    for (int i = 0; i < 5; i++) check($sformatf("s3_code%0d", i), pcode[i], exp_code[i]);
    check("s3_xfers", xfers, 25);
    check("s3_data", data_err, 0);
    check("s3_best_max", best_max, 9);
    check("s3_best_index", best_index, 3);
    check("s3_best_step", best_step, 1);
    check("s3_best_neg", best_neg, 0);
    repeat (3) @(negedge clk);
    check("s3_done_held", done, 1);

    // num_steps = 0 goes straight to done with cleared best
    start = 1'b1; num_steps = '0;
    @(negedge clk);
    start = 1'b0;
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_fsv", freq_step_valid, 0);
    check("z_best_max", best_max, 0);

    // Stalling slice, zero result never replaces
    tab_max[0] = 0; tab_idx[0] = 3;
    run_sweep(1, 1'b1, 1'b0);
    check("t_xfers", xfers, 5);
    check("t_data", data_err, 0);
    check("t_best_max", best_max, 0);
    check("t_best_index", best_index, 0);

    // Asynchronous reset in the middle of streaming
    @(negedge clk);
    start = 1'b1; num_steps = 10'd2; m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("r_pre_tvalid", s_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_tvalid", s_axis_tvalid, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    err = 0;
    repeat (4) begin
      @(negedge clk);
      if (freq_step_valid || s_axis_tvalid || busy) err++;
    end
    check("r_quiet", err, 0);

    // Restart with writes and starts hammered during the sweep
    tab_max[0] = 5; tab_idx[0] = 1;
    tab_max[1] = 6; tab_idx[1] = 2;
    tab_max[2] = 8; tab_idx[2] = 4;
    run_sweep(2, 1'b0, 1'b1);
    check("d_pulses", pcnt, 3);
    check("d_xfers", xfers, 15);
    check("d_data", data_err, 0);
    check("d_best_max", best_max, 8);
    check("d_best_index", best_index, 4);
    check("d_best_step", best_step, 1);
    check("d_best_neg", best_neg, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
